// File: rtl/y86_seq_controller.sv
// Multi-cycle sequencer for the Y86-64 SEQ datapath: walks each instruction
// through its stages with one-hot enables, owns the architectural PC, handles
// the data-memory handshake and tracks halt/error status and activity counters.
module y86_seq_controller #(
    parameter int unsigned     PC_W        = 64,
    parameter logic [PC_W-1:0] RESET_PC    = '0,
    parameter int unsigned     CNT_W       = 32,
    parameter int unsigned     MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       icode,
    input  logic             instr_valid,
    input  logic             imem_error,
    input  logic             mem_ready,
    input  logic             dmem_error,
    input  logic [PC_W-1:0]  pc_next,
    output logic [PC_W-1:0]  pc,
    output logic             en_fetch,
    output logic             en_decode,
    output logic             en_execute,
    output logic             en_memory,
    output logic             en_writeback,
    output logic             en_pcupd,
    output logic             mem_req,
    output logic [2:0]       stat,
    output logic             busy,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retired_cnt
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY,
        S_WRITEBACK, S_PCUPD, S_HALT, S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [2:0]        stat_q, stat_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  cyc_q, cyc_d;
    logic [CNT_W-1:0]  ret_q, ret_d;
    // en bit order: fetch, decode, execute, memory, writeback, pcupd
    logic [5:0]        en_q, en_d;
    logic              busy_q, busy_d;
    logic [WAIT_W-1:0] wait_inc;
    logic              mem_icode;

    assign wait_inc = wait_q + WAIT_W'(1);

    // Instructions that touch data memory: rmmovq, mrmovq, call, ret, pushq, popq
    always_comb begin
        unique case (icode)
            4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: mem_icode = 1'b1;
            default:                            mem_icode = 1'b0;
        endcase
    end

    // Next-state, PC, status and counter logic
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        stat_d  = stat_q;
        wait_d  = wait_q;
        ret_d   = ret_q;
        cyc_d   = cyc_q + CNT_W'(busy_q);

        unique case (state_q)
            S_IDLE:    if (start) state_d = S_FETCH;
            S_FETCH: begin
                if (imem_error) begin
                    state_d = S_ERR;
                    stat_d  = STAT_ADR;
                end else if (!instr_valid) begin
                    state_d = S_ERR;
                    stat_d  = STAT_INS;
                end else begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE:  state_d = S_EXECUTE;
            S_EXECUTE: begin
                if (icode == 4'h0) begin
                    // halt retires without a PC update
                    state_d = S_HALT;
                    stat_d  = STAT_HLT;
                    ret_d   = ret_q + CNT_W'(1);
                end else if (mem_icode) begin
                    state_d = S_MEMORY;
                    wait_d  = '0;
                end else begin
                    state_d = S_WRITEBACK;
                end
            end
            S_MEMORY: begin
                if (mem_ready) begin
                    if (dmem_error) begin
                        state_d = S_ERR;
                        stat_d  = STAT_ADR;
                    end else begin
                        state_d = S_WRITEBACK;
                    end
                end else begin
                    wait_d = wait_inc;
                    if (wait_inc == WAIT_W'(MEM_TIMEOUT)) begin
                        state_d = S_ERR;
                        stat_d  = STAT_ADR;
                    end
                end
            end
            S_WRITEBACK: state_d = S_PCUPD;
            S_PCUPD: begin
                pc_d    = pc_next;
                ret_d   = ret_q + CNT_W'(1);
                state_d = S_FETCH;
            end
            S_HALT, S_ERR: state_d = state_q;
            default: state_d = S_ERR;
        endcase
    end

    // Output decodes of the next state, registered so they line up with state_q
    always_comb begin
        en_d = 6'b0;
        unique case (state_d)
            S_FETCH:     en_d = 6'b000001;
            S_DECODE:    en_d = 6'b000010;
            S_EXECUTE:   en_d = 6'b000100;
            S_MEMORY:    en_d = 6'b001000;
            S_WRITEBACK: en_d = 6'b010000;
            S_PCUPD:     en_d = 6'b100000;
            default:     en_d = 6'b000000;
        endcase
        busy_d = |en_d;
    end

    // State and output registers; reset overrides everything mid-instruction
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            stat_q  <= STAT_AOK;
            wait_q  <= '0;
            cyc_q   <= '0;
            ret_q   <= '0;
            en_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            stat_q  <= stat_d;
            wait_q  <= wait_d;
            cyc_q   <= cyc_d;
            ret_q   <= ret_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
        end
    end

    assign pc           = pc_q;
    assign en_fetch     = en_q[0];
    assign en_decode    = en_q[1];
    assign en_execute   = en_q[2];
    assign en_memory    = en_q[3];
    assign en_writeback = en_q[4];
    assign en_pcupd     = en_q[5];
    assign mem_req      = en_q[3];
    assign stat         = stat_q;
    assign busy         = busy_q;
    assign cycle_cnt    = cyc_q;
    assign retired_cnt  = ret_q;

endmodule

// File: tb/tb_y86_seq_controller.sv
// Directed + randomized bench for y86_seq_controller. A per-instruction model
// lists the stages each instruction must visit and tracks PC/status/counters.
module tb_y86_seq_controller;

    localparam int          PC_W   = 64;
    localparam logic [63:0] RST_PC = 64'h100;
    localparam int          CNT_W  = 4;
    localparam int          TO     = 4;

    localparam int SF = 0, SD = 1, SE = 2, SM = 3, SW = 4, SP = 5, SN = 6;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [3:0]       icode = 4'h1;
    logic             instr_valid = 1'b1;
    logic             imem_error = 1'b0;
    logic             mem_ready = 1'b0;
    logic             dmem_error = 1'b0;
    logic [PC_W-1:0]  pc_next = '0;
    logic [PC_W-1:0]  pc;
    logic             en_fetch, en_decode, en_execute, en_memory, en_writeback, en_pcupd;
    logic             mem_req, busy;
    logic [2:0]       stat;
    logic [CNT_W-1:0] cycle_cnt, retired_cnt;

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    logic [63:0] m_pc;
    int          m_cyc, m_ret, m_stat;
    bit          m_busy;

    y86_seq_controller #(
        .PC_W(PC_W), .RESET_PC(RST_PC), .CNT_W(CNT_W), .MEM_TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .icode(icode),
        .instr_valid(instr_valid), .imem_error(imem_error),
        .mem_ready(mem_ready), .dmem_error(dmem_error), .pc_next(pc_next),
        .pc(pc), .en_fetch(en_fetch), .en_decode(en_decode),
        .en_execute(en_execute), .en_memory(en_memory),
        .en_writeback(en_writeback), .en_pcupd(en_pcupd),
        .mem_req(mem_req), .stat(stat), .busy(busy),
        .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input int st);
        logic [5:0] e;
        e = (st == SN) ? 6'b0 : (6'b1 << st);
        chk("en", 64'({en_pcupd, en_writeback, en_memory, en_execute, en_decode, en_fetch}), 64'(e));
        chk("mem_req", 64'(mem_req), 64'(st == SM));
        chk("busy", 64'(busy), 64'(m_busy));
        chk("pc", pc, m_pc);
        chk("stat", 64'(stat), 64'(m_stat));
        chk("cycle_cnt", 64'(cycle_cnt), 64'(m_cyc));
        chk("retired_cnt", 64'(retired_cnt), 64'(m_ret));
    endtask

    // check current cycle, then advance one clock; busy cycles bump the cycle count
    task automatic step(input int st);
        check_outs(st);
        @(posedge clk);
        @(negedge clk);
        if (m_busy) m_cyc = (m_cyc + 1) % (1 << CNT_W);
    endtask

    task automatic noise();
        mem_ready  = 1'($urandom);
        dmem_error = 1'($urandom);
    endtask

    task automatic model_reset();
        m_pc = RST_PC; m_cyc = 0; m_ret = 0; m_stat = 1; m_busy = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b1; noise();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        model_reset();
        check_outs(SN);
    endtask

    task automatic launch();
        start = 1'b1; noise();
        step(SN);
        start = 1'b0;
        m_busy = 1'b1;
    endtask

    task automatic frozen(input int n);
        repeat (n) begin
            start = 1'($urandom); noise();
            step(SN);
        end
        start = 1'b0;
    endtask

    // One instruction from FETCH; term=1 when it ends in HALT/ERR/reset
    task automatic run(input logic [3:0] ic, input bit iv, input bit ie, input int nwait,
                       input bit derr, input logic [63:0] pcn, input bit rst_mem, output bit term);
        term = 1'b0;
        icode = ic; instr_valid = iv; imem_error = ie; pc_next = pcn;
        noise(); step(SF);
        if (ie || !iv) begin
            m_busy = 0; m_stat = ie ? 3 : 4; term = 1'b1; return;
        end
        noise(); step(SD);
        noise(); step(SE);
        if (ic == 4'h0) begin
            m_busy = 0; m_stat = 2; m_ret = (m_ret + 1) % (1 << CNT_W); term = 1'b1; return;
        end
        if (ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB}) begin
            for (int k = 0; k < TO; k++) begin
                mem_ready  = (k == nwait);
                dmem_error = mem_ready ? derr : 1'($urandom);
                if (rst_mem) rst = 1'b1;
                step(SM);
                if (rst_mem) begin
                    rst = 1'b0; model_reset(); term = 1'b1; return;
                end
                if (k == nwait) begin
                    if (derr) begin
                        m_busy = 0; m_stat = 3; term = 1'b1; return;
                    end
                    break;
                end
                if (k == TO - 1) begin
                    m_busy = 0; m_stat = 3; term = 1'b1; return;
                end
            end
        end
        noise(); step(SW);
        noise(); step(SP);
        m_pc = pcn;
        m_ret = (m_ret + 1) % (1 << CNT_W);
    endtask

    initial begin
        bit t;
        logic [3:0] ric;
        model_reset();
        @(negedge clk);

        // reset state, then idle without start
        do_reset();
        repeat (2) begin noise(); step(SN); end

        // T1: OPq, MEMORY skipped, pc picks up pc_next
        launch();
        run(4'h6, 1, 0, 0, 0, 64'h0A, 0, t);
        chk("t1_pc", pc, 64'h0A);
        chk("t1_retired", 64'(retired_cnt), 64'd1);

        // T2: mrmovq with three wait cycles
        run(4'h5, 1, 0, 3, 0, {$urandom, $urandom}, 0, t);

        // random legal traffic; counters wrap
        for (int i = 0; i < 20; i++) begin
            ric = 4'($urandom_range(1, 15));
            run(ric, 1, 0, $urandom_range(0, TO - 2), 0, {$urandom, $urandom}, 0, t);
        end

        // T2 from reset: cycle_cnt = 9 on return to FETCH
        do_reset(); launch();
        run(4'h5, 1, 0, 3, 0, 64'h40, 0, t);
        chk("t2_cycle_cnt", 64'(cycle_cnt), 64'd9);

        // T5: halt after two OPq
        do_reset(); launch();
        run(4'h6, 1, 0, 0, 0, 64'h2, 0, t);
        run(4'h6, 1, 0, 0, 0, 64'h4, 0, t);
        run(4'h0, 1, 0, 0, 0, 64'h99, 0, t);
        chk("t5_term", 64'(t), 64'd1);
        frozen(4);

        // T4: illegal instruction, then imem_error priority
        do_reset(); launch();
        run(4'h6, 0, 0, 0, 0, 64'h8, 0, t);
        frozen(3);
        do_reset(); launch();
        run(4'h6, 0, 1, 0, 0, 64'h8, 0, t);
        frozen(3);

        // T3: memory timeout
        do_reset(); launch();
        run(4'h6, 1, 0, 0, 0, 64'h20, 0, t);
        run(4'hA, 1, 0, 99, 0, 64'h30, 0, t);
        frozen(3);

        // dmem_error with mem_ready
        do_reset(); launch();
        run(4'h8, 1, 0, 1, 1, 64'h50, 0, t);
        frozen(2);

        // T6: reset during MEMORY, then recover
        do_reset(); launch();
        run(4'h6, 1, 0, 0, 0, 64'h60, 0, t);
        run(4'h9, 1, 0, 0, 0, 64'h70, 1, t);
        check_outs(SN);
        launch();
        run(4'h2, 1, 0, 0, 0, 64'h80, 0, t);
        check_outs(SF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
